// File: rtl/e_in_ports_if.sv
// Bus bundle for the E/S input ports: device strobe/ack/data lines plus the CPU
// read side (id_in/rd/data_in/ready/ovf/irq).
interface e_in_ports_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in1, in2, in3, in4;
  logic             stb1, stb2, stb3, stb4;
  logic             ack1, ack2, ack3, ack4;
  logic [1:0]       id_in;
  logic             rd;
  logic [WIDTH-1:0] data_in;
  logic [3:0]       ready;
  logic [3:0]       ovf;
  logic             irq;

  modport master (
    output in1, in2, in3, in4, stb1, stb2, stb3, stb4, id_in, rd,
    input  ack1, ack2, ack3, ack4, data_in, ready, ovf, irq
  );
  modport slave (
    input  in1, in2, in3, in4, stb1, stb2, stb3, stb4, id_in, rd,
    output ack1, ack2, ack3, ack4, data_in, ready, ovf, irq
  );
endinterface

// File: rtl/e_in_ports.sv
// Four-port strobe/ack byte input block with per-port sync, capture FSM and status.
// Optional macro E_S_IRQ_EN: registered irq = |ready; otherwise irq is tied low.
module e_in_port_lane #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stb,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] hold,
  output logic             ready,
  output logic             ovf,
  output logic             ack
);
  typedef enum logic [1:0] {IDLE, FULL, DRAIN} st_t;
  st_t st, nxt;

  logic [SYNC_STAGES-1:0] sync;
  logic prev, s_stb, cap;

  assign s_stb = sync[SYNC_STAGES-1];
  assign cap   = s_stb & ~prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
      st   <= IDLE;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], stb};
      prev <= s_stb;
      st   <= nxt;
    end
  end

  always_comb begin
    nxt = st;
    case (st)
      IDLE:    if (cap) nxt = FULL;
      FULL:    if (rd_sel) nxt = s_stb ? DRAIN : IDLE;
      DRAIN:   if (!s_stb) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (st == FULL);
    ack   = (st != IDLE);
  end

  // A strobe arriving while FULL is dropped and flagged; the read clears the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold <= '0;
      ovf  <= 1'b0;
    end else begin
      if (st == IDLE && cap) hold <= din;
      if (st == FULL) begin
        if (rd_sel)   ovf <= 1'b0;
        else if (cap) ovf <= 1'b1;
      end
    end
  end
endmodule

module e_in_ports #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          reset,
  e_in_ports_if.slave  bus
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][WIDTH-1:0] din, hold;
  logic [NUM_LANES-1:0]            stb, ack, rdy, ovf;

  assign din = {bus.in4, bus.in3, bus.in2, bus.in1};
  assign stb = {bus.stb4, bus.stb3, bus.stb2, bus.stb1};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    e_in_port_lane #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .stb    (stb[i]),
      .din    (din[i]),
      .rd_sel (bus.rd && (bus.id_in == 2'(i))),
      .hold   (hold[i]),
      .ready  (rdy[i]),
      .ovf    (ovf[i]),
      .ack    (ack[i])
    );
  end

  assign bus.data_in = hold[bus.id_in];
  assign bus.ready   = rdy;
  assign bus.ovf     = ovf;
  assign bus.ack1    = ack[0];
  assign bus.ack2    = ack[1];
  assign bus.ack3    = ack[2];
  assign bus.ack4    = ack[3];

`ifdef E_S_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= |rdy;
  end
  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_e_in_ports.sv
// Directed bench for e_in_ports: expectations are queued by the stimulus and
// compared by a negedge monitor against the DUT outputs.
module tb_e_in_ports;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  e_in_ports_if #(.WIDTH(8)) bus ();

  e_in_ports #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] ready;
    logic [3:0] ovf;
    logic [3:0] ack;
    logic [7:0] data;
    logic       irq;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic irq_x(input logic v);
`ifdef E_S_IRQ_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [3:0] a;
      e = exp_q.pop_front();
      a = {bus.ack4, bus.ack3, bus.ack2, bus.ack1};
      checks++;
      if (bus.ready !== e.ready || bus.ovf !== e.ovf || a !== e.ack ||
          bus.data_in !== e.data || bus.irq !== e.irq) begin
        errors++;
        $display("FAIL %s: got ready=%b ovf=%b ack=%b data=%h irq=%b, want ready=%b ovf=%b ack=%b data=%h irq=%b",
                 e.name, bus.ready, bus.ovf, a, bus.data_in, bus.irq,
                 e.ready, e.ovf, e.ack, e.data, e.irq);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Queue an expectation and let the monitor consume it at the next falling edge.
  task automatic chk(input string nm, input logic [3:0] r, input logic [3:0] o,
                     input logic [3:0] a, input logic [7:0] d, input logic irq_en_val);
    exp_t e;
    e.name = nm; e.ready = r; e.ovf = o; e.ack = a; e.data = d; e.irq = irq_x(irq_en_val);
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.in1 = '0; bus.in2 = '0; bus.in3 = '0; bus.in4 = '0;
    bus.stb1 = 0; bus.stb2 = 0; bus.stb3 = 0; bus.stb4 = 0;
    bus.id_in = 2'd0; bus.rd = 1'b0;
    tick(2);
    reset = 1'b0;
    chk("rst_idle", 4'h0, 4'h0, 4'h0, 8'h00, 0);

    // single transfer on port 2
    bus.in2 = 8'hA5; bus.stb2 = 1; bus.id_in = 2'd1;
    tick(2);
    chk("t2_pre",  4'h0, 4'h0, 4'h0, 8'h00, 0);
    tick();
    chk("t2_cap",  4'b0010, 4'h0, 4'b0010, 8'hA5, 0);
    tick();
    chk("t2_irq",  4'b0010, 4'h0, 4'b0010, 8'hA5, 1);
    bus.stb2 = 0;
    tick(3);
    chk("t2_hold", 4'b0010, 4'h0, 4'b0010, 8'hA5, 1);
    bus.rd = 1; tick(); bus.rd = 0;
    chk("t2_rd",   4'h0, 4'h0, 4'h0, 8'hA5, 1);
    tick();
    chk("t2_irq0", 4'h0, 4'h0, 4'h0, 8'hA5, 0);

    // read while strobe still high -> DRAIN
    bus.in3 = 8'h3C; bus.stb3 = 1; bus.id_in = 2'd2;
    tick(3);
    chk("t3_full",  4'b0100, 4'h0, 4'b0100, 8'h3C, 0);
    bus.rd = 1; tick(); bus.rd = 0;
    chk("t3_drain", 4'h0, 4'h0, 4'b0100, 8'h3C, 1);
    bus.stb3 = 0;
    tick(2);
    chk("t3_drain_hold", 4'h0, 4'h0, 4'b0100, 8'h3C, 0);
    tick();
    chk("t3_idle",  4'h0, 4'h0, 4'h0, 8'h3C, 0);

    // overrun on port 1
    bus.in1 = 8'h11; bus.stb1 = 1; bus.id_in = 2'd0;
    tick(3);
    bus.stb1 = 0;
    tick(3);
    chk("t4_full", 4'b0001, 4'h0, 4'b0001, 8'h11, 1);
    bus.in1 = 8'h22; bus.stb1 = 1;
    tick(3);
    chk("t4_ovf",  4'b0001, 4'b0001, 4'b0001, 8'h11, 1);
    bus.stb1 = 0;
    tick(3);
    bus.rd = 1; tick(); bus.rd = 0;
    chk("t4_rd",   4'h0, 4'h0, 4'h0, 8'h11, 1);
    tick();

    // all four ports at once
    bus.in1 = 8'h01; bus.in2 = 8'h02; bus.in3 = 8'h03; bus.in4 = 8'h04;
    bus.stb1 = 1; bus.stb2 = 1; bus.stb3 = 1; bus.stb4 = 1;
    bus.id_in = 2'd0;
    tick(3);
    chk("t5_all", 4'hF, 4'h0, 4'hF, 8'h01, 0);
    bus.stb1 = 0; bus.stb2 = 0; bus.stb3 = 0; bus.stb4 = 0;
    tick(3);
    bus.id_in = 2'd2; bus.rd = 1; tick(); bus.rd = 0;
    chk("t5_rd",  4'hB, 4'h0, 4'hB, 8'h03, 1);
    bus.id_in = 2'd0; chk("t5_h1", 4'hB, 4'h0, 4'hB, 8'h01, 1);
    bus.id_in = 2'd1; chk("t5_h2", 4'hB, 4'h0, 4'hB, 8'h02, 1);
    bus.id_in = 2'd3; chk("t5_h4", 4'hB, 4'h0, 4'hB, 8'h04, 1);

    // async reset mid-cycle, strobe held high through release
    bus.in4 = 8'h77; bus.stb4 = 1;
    tick();
    reset = 1'b1;
    chk("rst_async", 4'h0, 4'h0, 4'h0, 8'h00, 0);
    tick();
    reset = 1'b0;
    tick(2);
    chk("rst_stb_pre", 4'h0, 4'h0, 4'h0, 8'h00, 0);
    tick();
    chk("rst_stb_cap", 4'b1000, 4'h0, 4'b1000, 8'h77, 0);

    tick();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
